// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V pipeline.
// Memory access sizes, MEM stage states and byte-lane helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // The reserved size encoding 2'b11 is handled as a word access.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == BYTE): m = 1'b0;
      (size == HALF): m = a[0];
      default:        m = |a;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == BYTE): be = 4'b0001 << a;
      (size == HALF): be = a[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] wdata_gen(
    input logic [1:0]      size,
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] w;
    w = d;
    unique case (1'b1)
      (size == BYTE): w = {4{d[7:0]}};
      (size == HALF): w = {2{d[15:0]}};
      default:        w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Load data alignment for the MEM stage.
// Shifts the bus word down to the addressed lane and extends it.
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  mem_size_t       size,
  input  logic            zext,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {addr, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (size)
      BYTE: ld_data = zext ? {24'd0, sh[7:0]}
                           : {{24{sh[7]}}, sh[7:0]};
      HALF: ld_data = zext ? {16'd0, sh[15:0]}
                           : {{16{sh[15]}}, sh[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_mem_stage.sv
// RISC-V MEM stage: data memory access and writeback bundle.
// One outstanding bus request; upstream stalls while it is pending.
module riscv_mem_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misaligned_err
);

  mem_state_t state, state_nx;

  logic            accept;
  logic            is_mem;
  logic            mis;
  logic            go_busy;
  logic            done;
  logic [1:0]      lat_off;
  mem_size_t       lat_size;
  logic            lat_uns;
  logic            lat_load;
  logic            lat_rw;
  logic [XLEN-1:0] ld_val;

  assign stall   = (state == BUSY);
  assign accept  = (state == IDLE) && in_valid;
  assign is_mem  = mem_read | mem_write;
  assign mis     = is_mem && misaligned(mem_size, alu_result[1:0]);
  assign go_busy = accept && is_mem && !mis;
  assign done    = (state == BUSY) && dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go_busy)    state_nx = BUSY;
      BUSY:    if (dmem_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  riscv_load_align u_align (
    .rdata   (dmem_rdata),
    .addr    (lat_off),
    .size    (lat_size),
    .zext    (lat_uns),
    .ld_data (ld_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      misaligned_err <= 1'b0;
      lat_off        <= '0;
      lat_size       <= BYTE;
      lat_uns        <= 1'b0;
      lat_load       <= 1'b0;
      lat_rw         <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      misaligned_err <= 1'b0;
      if (accept) begin
        wb_rd <= rd_addr;
        if (!is_mem) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= reg_write;
          wb_data      <= alu_result;
        end else if (mis) begin
          wb_valid       <= 1'b1;
          misaligned_err <= 1'b1;
          wb_data        <= '0;
        end else begin
          dmem_req   <= 1'b1;
          dmem_we    <= mem_write;
          dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
          dmem_be    <= be_gen(mem_size, alu_result[1:0]);
          dmem_wdata <= wdata_gen(mem_size, store_data);
          lat_off    <= alu_result[1:0];
          lat_size   <= mem_size_t'(mem_size);
          lat_uns    <= mem_unsigned;
          lat_load   <= !mem_write;
          lat_rw     <= reg_write;
        end
      end else if (done) begin
        dmem_req     <= 1'b0;
        dmem_we      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_reg_write <= lat_load & lat_rw;
        wb_data      <= lat_load ? ld_val : '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Testbench for riscv_mem_stage.
// Scoreboard queue filled at issue; monitor pops on each wb_valid.
module tb_riscv_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned_err;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  riscv_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .rd_addr        (rd_addr),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .stall          (stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misaligned_err (misaligned_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb act=1 exp=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
        chk("wb_data", wb_data, e.data);
        chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, e.err});
        if (e.rw) chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw,
                       input logic [1:0] sz, input logic u);
    int n;
    n = 0;
    while (stall !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("issue_timeout", 32'd1, 32'd0);
    in_valid     = 1'b1;
    alu_result   = a;
    store_data   = d;
    rd_addr      = rd;
    reg_write    = rw;
    mem_read     = mr;
    mem_write    = mw;
    mem_size     = sz;
    mem_unsigned = u;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic serve(input int dly, input logic [31:0] rdata,
                       input logic [31:0] ea, input logic [3:0] ebe,
                       input logic ewe, input logic [31:0] ewd);
    for (int i = 0; i < dly; i++) begin
      chk("busy_req", {31'd0, dmem_req}, 32'd1);
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_addr", dmem_addr, ea);
      chk("busy_be", {28'd0, dmem_be}, {28'd0, ebe});
      chk("busy_we", {31'd0, dmem_we}, {31'd0, ewe});
      if (ewe) chk("busy_wdata", dmem_wdata, ewd);
      @(posedge clk); #1;
    end
    chk("ready_addr", dmem_addr, ea);
    chk("ready_be", {28'd0, dmem_be}, {28'd0, ebe});
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, dmem_req}, 32'd0);
  endtask

  function automatic exp_t mk(input logic rw, input logic [4:0] rd,
                              input logic [31:0] d, input logic err);
    exp_t e;
    e.rw = rw; e.rd = rd; e.data = d; e.err = err;
    return e;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0;
    rd_addr = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_size = 2'b10; mem_unsigned = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbrw", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, misaligned_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through, then two back-to-back ops
    sb.push_back(mk(1, 5'd5, 32'h1234, 0));
    issue(32'h1234, 0, 5'd5, 1, 0, 0, 2'b10, 0);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    sb.push_back(mk(1, 5'd1, 32'hA, 0));
    issue(32'hA, 0, 5'd1, 1, 0, 0, 2'b10, 0);
    sb.push_back(mk(0, 5'd2, 32'hB, 0));
    issue(32'hB, 0, 5'd2, 0, 0, 0, 2'b10, 0);

    // word store, ready after 3 cycles
    sb.push_back(mk(0, 5'd0, 32'h0, 0));
    issue(32'h100, 32'hDEADBEEF, 5'd3, 0, 0, 1, 2'b10, 0);
    serve(3, 32'h0, 32'h100, 4'b1111, 1, 32'hDEADBEEF);

    // byte loads at 0x203
    sb.push_back(mk(1, 5'd7, 32'hFFFFFF80, 0));
    issue(32'h203, 0, 5'd7, 1, 1, 0, 2'b00, 0);
    serve(1, 32'h80FFFFFF, 32'h200, 4'b1000, 0, 0);
    sb.push_back(mk(1, 5'd8, 32'h00000080, 0));
    issue(32'h203, 0, 5'd8, 1, 1, 0, 2'b00, 1);
    serve(0, 32'h80FFFFFF, 32'h200, 4'b1000, 0, 0);

    // half loads
    sb.push_back(mk(1, 5'd9, 32'hFFFFBEEF, 0));
    issue(32'h202, 0, 5'd9, 1, 1, 0, 2'b01, 0);
    serve(2, 32'hBEEF1234, 32'h200, 4'b1100, 0, 0);
    sb.push_back(mk(1, 5'd10, 32'h00001234, 0));
    issue(32'h200, 0, 5'd10, 1, 1, 0, 2'b01, 1);
    serve(0, 32'hBEEF1234, 32'h200, 4'b0011, 0, 0);

    // word load
    sb.push_back(mk(1, 5'd11, 32'h87654321, 0));
    issue(32'h404, 0, 5'd11, 1, 1, 0, 2'b10, 0);
    serve(1, 32'h87654321, 32'h404, 4'b1111, 0, 0);

    // byte and half stores with lane replication
    sb.push_back(mk(0, 5'd0, 32'h0, 0));
    issue(32'h101, 32'h000000AB, 5'd4, 0, 0, 1, 2'b00, 0);
    serve(1, 0, 32'h100, 4'b0010, 1, 32'hABABABAB);
    sb.push_back(mk(0, 5'd0, 32'h0, 0));
    issue(32'h102, 32'h1234CAFE, 5'd4, 0, 0, 1, 2'b01, 0);
    serve(1, 0, 32'h100, 4'b1100, 1, 32'hCAFECAFE);

    // misaligned accesses
    sb.push_back(mk(0, 5'd0, 32'h0, 1));
    issue(32'h101, 0, 5'd6, 1, 1, 0, 2'b10, 0);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    sb.push_back(mk(0, 5'd0, 32'h0, 1));
    issue(32'h203, 32'h55, 5'd6, 0, 0, 1, 2'b01, 0);
    chk("mis2_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;

    // ready while idle must be ignored
    dmem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_rdy_stall", {31'd0, stall}, 32'd0);
    end
    dmem_ready = 1'b0;

    // reset during BUSY abandons the request
    issue(32'h300, 0, 5'd12, 1, 1, 0, 2'b10, 0);
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, dmem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    dmem_ready = 1'b0;
    chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
    sb.push_back(mk(1, 5'd13, 32'hCAFE0001, 0));
    issue(32'hCAFE0001, 0, 5'd13, 1, 0, 0, 2'b10, 0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
